// File: rtl/fetch_predict_pkg.sv
// fetch_predict_pkg: shared fetch-stage constants, next-PC selector and branch decode helper
package fetch_predict_pkg;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [1:0] BHT_RST = 2'b01;
  localparam logic [1:0] CNT_MAX = 2'b11;
  localparam logic [1:0] CNT_MIN = 2'b00;
  typedef enum logic [1:0] {
    NPC_REDIRECT = 2'd0,
    NPC_ADVANCE  = 2'd1,
    NPC_HOLD     = 2'd2
  } npc_sel_e;
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: bimodal table of 2-bit saturating counters, one read and one update port
module bht_2bit
  import fetch_predict_pkg::*;
#(
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_cnt,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);
  localparam int N = 1 << BHT_IDX_W;
  logic [1:0] cnt [N];
  logic [1:0] cur;
  assign rd_cnt = cnt[rd_idx];
  assign cur = cnt[upd_idx];
  // reset all counters to weak-not-taken; otherwise saturating step on update
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < N; i++) cnt[i] <= BHT_RST;
    else if (upd_valid)
      cnt[upd_idx] <= upd_taken ? (cur == CNT_MAX ? CNT_MAX : cur + 2'd1)
                                : (cur == CNT_MIN ? CNT_MIN : cur - 2'd1);
endmodule

// File: rtl/fetch_predict.sv
// fetch_predict: IF stage with PC register, bimodal branch prediction and perf counters
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       imem_data_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [31:0]       instr_o,
  output logic              pred_taken_o,
  output logic              ifid_flush_o,
  output logic [CNT_W-1:0]  perf_br_o,
  output logic [CNT_W-1:0]  perf_mis_o
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [1:0]        cnt;
  npc_sel_e          sel;
  logic              unused_bits;
  assign imem_addr_o  = pc;
  assign pc_plus4_o   = pc + ADDR_W'(4);
  assign instr_o      = imem_data_i;
  assign target       = pc_plus4_o + ADDR_W'($signed({imem_data_i[15:0], 2'b00}));
  assign pred_taken_o = is_branch(imem_data_i[31:26]) & cnt[1];
  assign ifid_flush_o = redirect_i;
  assign sel          = redirect_i ? NPC_REDIRECT : pc_write_i ? NPC_ADVANCE : NPC_HOLD;
  assign unused_bits  = ^{imem_data_i[25:16], cnt[0], upd_pc_i[ADDR_W-1:BHT_IDX_W+2], upd_pc_i[1:0]};
  bht_2bit #(.BHT_IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_cnt    (cnt),
    .upd_valid (upd_valid_i),
    .upd_idx   (upd_pc_i[BHT_IDX_W+1:2]),
    .upd_taken (upd_taken_i)
  );
  // PC: redirect beats stall; advance follows the prediction
  always_ff @(posedge clk_i)
    if (rst_i) pc <= '0;
    else if (sel == NPC_REDIRECT) pc <= redirect_pc_i;
    else if (sel == NPC_ADVANCE) pc <= pred_taken_o ? target : pc_plus4_o;
  // perf counters saturate at all-ones
  always_ff @(posedge clk_i)
    if (rst_i) begin
      perf_br_o  <= '0;
      perf_mis_o <= '0;
    end else begin
      if (upd_valid_i && !(&perf_br_o)) perf_br_o <= perf_br_o + CNT_W'(1);
      if (redirect_i && !(&perf_mis_o)) perf_mis_o <= perf_mis_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_fetch_predict.sv
// tb_fetch_predict: random and directed stimulus checked against a behavioural fetch model
module tb_fetch_predict;
  logic        clk = 0;
  logic        rst = 1, pc_write = 0, redirect = 0, upd_valid = 0, upd_taken = 0;
  logic [31:0] redirect_pc = 0, upd_pc = 0, instr = 0;
  logic [31:0] imem_addr, pc_plus4, instr_out;
  logic        pred_taken, ifid_flush;
  logic [15:0] perf_br, perf_mis;

  int tests = 0, fails = 0;
  bit armed = 0;
  logic [31:0] m_pc;
  int m_bht [16];
  int m_br, m_mis;

  always #5 clk = ~clk;

  fetch_predict dut (
    .clk_i(clk), .rst_i(rst), .pc_write_i(pc_write), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_taken_i(upd_taken), .imem_data_i(instr), .imem_addr_o(imem_addr),
    .pc_plus4_o(pc_plus4), .instr_o(instr_out), .pred_taken_o(pred_taken),
    .ifid_flush_o(ifid_flush), .perf_br_o(perf_br), .perf_mis_o(perf_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pred();
    int op = int'(instr[31:26]);
    return (op == 4 || op == 5) && m_bht[(m_pc / 4) % 16] >= 2;
  endfunction

  function automatic logic [31:0] m_target();
    int off = int'($signed(instr[15:0])) * 4;
    return m_pc + 32'd4 + 32'(off);
  endfunction

  task automatic model_step();
    int idx;
    if (rst) begin
      m_pc = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
      m_br = 0;
      m_mis = 0;
    end else begin
      if (redirect) m_pc = redirect_pc;
      else if (pc_write) m_pc = m_pred() ? m_target() : m_pc + 32'd4;
      if (upd_valid) begin
        idx = int'(upd_pc / 4) % 16;
        m_bht[idx] = upd_taken ? (m_bht[idx] == 3 ? 3 : m_bht[idx] + 1)
                               : (m_bht[idx] == 0 ? 0 : m_bht[idx] - 1);
        if (m_br < 65535) m_br++;
      end
      if (redirect && m_mis < 65535) m_mis++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (armed) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr_out, instr);
      chk("pred_taken", 32'(pred_taken), 32'(m_pred()));
      chk("ifid_flush", 32'(ifid_flush), 32'(redirect));
      chk("perf_br", 32'(perf_br), 32'(m_br));
      chk("perf_mis", 32'(perf_mis), 32'(m_mis));
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_step();
    armed = 1;
    #1;
  endtask

  task automatic tick();
    settle();
    clk_edge();
  endtask

  task automatic drive(input logic r, pw, rd, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] ins);
    rst = r; pc_write = pw; redirect = rd; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; instr = ins;
  endtask

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 3);
    w[31:26] = sel == 0 ? 6'b000100 : sel == 1 ? 6'b000101 : w[31:26];
    return w;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("reset addr", imem_addr, 32'h0);
    chk("reset plus4", pc_plus4, 32'h4);
    chk("reset pred", 32'(pred_taken), 32'h0);
    chk("reset perf_br", 32'(perf_br), 32'h0);
    clk_edge();
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("step addr", imem_addr, 32'(4 * i));
      clk_edge();
    end
    drive(0, 1, 0, 0, 0, 0, 0, beq(16'h0003));
    settle();
    chk("beq fresh pred", 32'(pred_taken), 32'h0);
    clk_edge();
    drive(0, 0, 0, 0, 1, 32'h10, 1, 0);
    settle();
    chk("beq not-taken next", imem_addr, 32'h14);
    clk_edge();
    tick();
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, beq(16'h0003));
    settle();
    chk("beq trained pred", 32'(pred_taken), 32'h1);
    clk_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("beq taken target", imem_addr, 32'h20);
    clk_edge();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall hold", imem_addr, 32'h40);
      clk_edge();
    end
    drive(0, 0, 1, 32'h100, 0, 0, 0, 0);
    settle();
    chk("redirect flush", 32'(ifid_flush), 32'h1);
    clk_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("redirect addr", imem_addr, 32'h100);
    chk("perf_mis one", 32'(perf_mis), 32'h1);
    clk_edge();
    drive(0, 0, 0, 0, 1, 32'h8, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    drive(0, 0, 1, 32'h8, 1, 32'h8, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, beq(16'hFFFF));
    settle();
    chk("sat low pred", 32'(pred_taken), 32'h0);
    clk_edge();
    drive(0, 0, 0, 0, 1, 32'h8, 1, beq(16'hFFFF));
    tick();
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, beq(16'hFFFF));
    settle();
    chk("neg imm pred", 32'(pred_taken), 32'h1);
    clk_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("neg imm target", imem_addr, 32'h8);
    clk_edge();
    drive(0, 0, 1, 32'h14, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h14, 1, beq(16'h0010));
    settle();
    chk("same-cycle pre", 32'(pred_taken), 32'h0);
    clk_edge();
    drive(0, 0, 0, 0, 0, 0, 0, beq(16'h0010));
    settle();
    chk("same-cycle post", 32'(pred_taken), 32'h1);
    clk_edge();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, {$urandom_range(0, 255), 2'b00},
            $urandom_range(0, 2) != 0, $urandom, 1'($urandom), rand_instr());
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1'($urandom), 0, 0, 1, $urandom, 1'($urandom), rand_instr());
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("perf_br preload", 32'(perf_br), 32'hFFFF);
    clk_edge();
    drive(0, 1, 1, 32'h200, 1, 32'h0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("perf_br saturated", 32'(perf_br), 32'hFFFF);
    clk_edge();
    drive(1, 1, 1, 32'h300, 1, 32'h0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, beq(16'h0004));
    settle();
    chk("midrst addr", imem_addr, 32'h0);
    chk("midrst pred", 32'(pred_taken), 32'h0);
    chk("midrst perf_br", 32'(perf_br), 32'h0);
    chk("midrst perf_mis", 32'(perf_mis), 32'h0);
    clk_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
